// File: rtl/vedic_mul_arbiter.sv
// Round-robin front end sharing one pipelined multiplier between N_REQ requesters.
// Carries a valid/ID shadow pipeline aligned with the multiplier latency.
module vedic_mul_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DW      = 64,
  parameter int unsigned MUL_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_en,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_a,
  input  logic [N_REQ*DW-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DW-1:0]         mul_a,
  output logic [DW-1:0]         mul_b,
  input  logic [2*DW-1:0]       mul_s,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [2*DW-1:0]       rsp_s,
  output logic                  busy
);

  // Stage 0 loads with the operand registers; the last stage lines up with mul_s.
  localparam int unsigned Depth = MUL_LAT + 1;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            grant;
  logic [ID_W-1:0] win_id;
  logic [DW-1:0]   mul_a_q, mul_b_q;
  logic [Depth-1:0] sv_q;
  logic [ID_W-1:0]  sid_q [Depth];

  always_comb begin
    int unsigned idx;
    grant     = 1'b0;
    win_id    = '0;
    req_ready = '0;
    idx       = 0;
    if (issue_en && rst_n) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        idx = (32'(ptr_q) + 32'(j)) % N_REQ;
        if (!grant && req_valid[idx]) begin
          grant  = 1'b1;
          win_id = ID_W'(idx);
        end
      end
    end
    if (grant) begin
      req_ready[win_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = ID_W'((32'(win_id) + 32'd1) % N_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant) begin
        mul_a_q <= req_a[32'(win_id)*DW +: DW];
        mul_b_q <= req_b[32'(win_id)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        sid_q[i] <= '0;
      end
    end else begin
      sv_q     <= {sv_q[Depth-2:0], grant};
      sid_q[0] <= win_id;
      for (int i = 1; i < int'(Depth); i++) begin
        sid_q[i] <= sid_q[i-1];
      end
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = sv_q[Depth-1];
  assign rsp_id    = sid_q[Depth-1];
  assign rsp_s     = mul_s;
  assign busy      = |sv_q;

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Randomized bench for vedic_mul_arbiter with a behavioural multiplier and a
// scoreboard model of round-robin grants and timed responses.
module tb_vedic_mul_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int DW  = 64;
  localparam int LAT = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_en;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   mul_a, mul_b;
  logic [2*DW-1:0] mul_s;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [2*DW-1:0] rsp_s;
  logic            busy;

  vedic_mul_arbiter #(.N_REQ(N), .ID_W(IW), .DW(DW), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_en  (issue_en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_s     (mul_s),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: product appears LAT edges after the operands change.
  logic [2*DW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_s = mpipe[LAT-1];

  typedef struct {
    int           id;
    logic [127:0] p;
    int           due;
  } rsp_t;

  rsp_t q[$];
  int   mptr = 0;
  int   e = 0;
  int   mode = 0;  // 0: hold, 1: random, 2: all requesters always valid
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(7, 0))
      0:       return '0;
      1:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic restim(input int win);
    for (int i = 0; i < N; i++) begin
      if (win == i) req_valid[i] = 1'b0;
      if (!req_valid[i] && (mode == 2 || (mode == 1 && $urandom_range(1, 0) == 1))) begin
        req_valid[i]        = 1'b1;
        req_a[i*DW +: DW]   = rand_op();
        req_b[i*DW +: DW]   = rand_op();
      end
    end
    if (mode == 1) issue_en = ($urandom_range(7, 0) != 0);
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int           win;
    logic [N-1:0] exp_rdy;
    logic [127:0] prod;
    @(negedge clk);
    win  = -1;
    prod = '0;
    if (rst_n && issue_en) begin
      for (int j = 0; j < N; j++) begin
        if (win < 0 && req_valid[(mptr + j) % N]) win = (mptr + j) % N;
      end
    end
    exp_rdy = '0;
    if (win >= 0) begin
      exp_rdy[win] = 1'b1;
      prod = 128'(req_a[win*DW +: DW]) * 128'(req_b[win*DW +: DW]);
    end
    check("req_ready", req_ready, exp_rdy);
    check("busy", busy, q.size() != 0);
    if (q.size() != 0 && q[0].due == e) begin
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_id", rsp_id, q[0].id);
      check("rsp_s", rsp_s, q[0].p);
      void'(q.pop_front());
    end else begin
      check("rsp_valid_idle", rsp_valid, 1'b0);
      if (q.size() != 0 && q[0].due < e) begin
        check("rsp_missing", 1'b1, 1'b0);
        void'(q.pop_front());
      end
    end
    @(posedge clk);
    e++;
    if (win >= 0) begin
      q.push_back('{id: win, p: prod, due: e + LAT});
      mptr = (win + 1) % N;
    end
    #1;
    restim(win);
  endtask

  task automatic drain();
    mode = 0;
    for (int n = 0; n < 60 && (q.size() != 0 || req_valid != '0); n++) step();
    check("drain_done", q.size(), 0);
    step();
    check("busy_after_drain", busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    issue_en  = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    #12;
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_mul_a", mul_a, 64'd0);
    check("rst_mul_b", mul_b, 64'd0);
    req_valid = '0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2.
    req_valid       = 4'b0100;
    req_a[2*DW +: DW] = 64'd3;
    req_b[2*DW +: DW] = 64'd5;
    drain();

    // Extremes: all-ones squared, and zero times anything.
    req_valid         = 4'b0011;
    req_a[0 +: DW]    = '1;
    req_b[0 +: DW]    = '1;
    req_a[DW +: DW]   = '0;
    req_b[DW +: DW]   = {$urandom, $urandom};
    drain();
    check("ext_const", 128'(64'hFFFF_FFFF_FFFF_FFFF) * 128'(64'hFFFF_FFFF_FFFF_FFFF),
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Full contention with an issue_en gap.
    mode = 2;
    restim(-1);
    repeat (12) step();
    issue_en = 1'b0;
    repeat (3) step();
    issue_en = 1'b1;
    repeat (12) step();
    drain();

    // Random soak.
    mode = 1;
    repeat (1000) step();
    issue_en = 1'b1;
    drain();

    // Reset mid-flight.
    mode = 2;
    restim(-1);
    repeat (3) step();
    mode     = 0;
    issue_en = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    issue_en = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 4'b0000);
    @(negedge clk);
    check("midrst_req_ready2", req_ready, 4'b0000);
    q.delete();
    mptr     = 0;
    issue_en = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    e++;
    #1;
    issue_en = 1'b1;
    mode     = 2;
    restim(-1);
    repeat (12) step();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vedic_mul_arbiter.md
# vedic_mul_arbiter

Round-robin arbiter and in-flight tracker that shares one `simple_vedic_64bit` pipelined multiplier between `N_REQ` requesters. It accepts at most one operand pair per cycle, drives the multiplier operand registers, and carries a valid/ID shadow pipeline matched to the multiplier latency. Each product is then returned on a shared response bus tagged with the requester ID. It sits between the IDDMM word-level controllers and the multiplier instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ID_W`, 2: requester ID width, equal to ceil(log2(N_REQ)).
- `DW`, 64: operand width; the product is 2*DW.
- `MUL_LAT`, 6: multiplier latency in clock edges, from `mul_a`/`mul_b` changing to `mul_s` holding their product.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_en`  in  1  while low, no new grants are made; the in-flight pipeline keeps draining.
- `req_valid`  in  N_REQ  bit i: requester i has an operand pair pending.
- `req_a`  in  N_REQ*DW  requester i operand A at `[i*DW +: DW]`.
- `req_b`  in  N_REQ*DW  requester i operand B at `[i*DW +: DW]`.
- `req_ready`  out  N_REQ  one-hot or zero grant; combinational from `req_valid`, `issue_en` and the RR pointer.
- `mul_a`  out  DW  registered operand A to the multiplier.
- `mul_b`  out  DW  registered operand B to the multiplier.
- `mul_s`  in  2*DW  multiplier product.
- `rsp_valid`  out  1  response valid; no backpressure.
- `rsp_id`  out  ID_W  ID of the requester that owns the response.
- `rsp_s`  out  2*DW  product; equals `mul_s`, meaningful only while `rsp_valid` is high.
- `busy`  out  1  high while any accepted transaction has not yet produced its response.

## Operation
- Handshake: a transfer occurs on an edge where `req_valid[i] & req_ready[i]` is high. The requester holds `req_a`/`req_b` stable until that edge.
- Arbitration:
  - Priority starts at `ptr` and runs upward modulo N_REQ; the first requester with `req_valid` high wins.
  - `req_ready` is all zero when `issue_en` is low or no requester is valid.
  - `req_ready` never depends on `req_ready` itself, so requesters can evaluate it without combinational loops.
- Pointer: after a grant to requester i, `ptr <= (i+1) mod N_REQ`. With no grant, `ptr` holds. With a single active requester, that requester is granted every cycle.
- Operands: on a grant edge, `mul_a`/`mul_b` load the winner's operands. Otherwise they hold their previous value; the multiplier output is then ignored.
- Shadow pipeline: a valid bit plus ID for each grant, advanced every cycle, with depth chosen so responses align with `mul_s`. There is no stall path, so throughput is one product per cycle.
- Response ordering: responses return in grant order. IDs are never reordered or dropped.
- `busy` is the OR of all shadow valid bits, including the stage feeding `rsp_valid`.
- Multiplier protocol: the multiplier has no reset and no valid signal. Correctness relies only on the shadow pipeline.

## Timing
- Reset values (asynchronous, on `rst_n` low): `mul_a`=0, `mul_b`=0, `ptr`=0, all shadow valid bits =0. Hence `rsp_valid`=0, `rsp_id`=0 and `busy`=0.
- While `rst_n` is low, `req_ready` = 0.
- Latency: a transfer accepted at edge k gives `rsp_valid`=1 and `rsp_s`=A*B in the cycle after edge k+MUL_LAT, which is exactly one cycle wide.
- Back-to-back: grants at edges k, k+1, k+2 give responses in the three consecutive cycles after edges k+MUL_LAT, k+MUL_LAT+1 and k+MUL_LAT+2.
- Reset mid-operation: all in-flight transactions are discarded and no response is produced for them. The first grant after reset release starts at requester 0.
- `issue_en` falling: it blocks a grant in the same cycle, because `req_ready` is combinational. Transactions already accepted still complete.
- `busy` falls in the cycle after the last response cycle.
- `issue_en` low with `req_valid` high: nothing is accepted and `ptr` holds.

## Test plan
- Single request: requester 2 sends A=3, B=5 at edge 10. Required: `req_ready`=4'b0100 in the cycle before edge 10. `rsp_valid`=1, `rsp_id`=2, `rsp_s`=15 only in the cycle after edge 16. `busy` is high from after edge 10 until after edge 16.
- Full contention: all four requesters valid continuously from reset. Required: grant order 0,1,2,3,0,1,… and `rsp_id` follows the same order six cycles later, with `rsp_valid` continuously high.
- Extremes: A=B=0xFFFF_FFFF_FFFF_FFFF. Required: `rsp_s`=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. A=0 with any B gives 0.
- Random soak: 1000 cycles of random `req_valid` and operands, checked against a reference model queue of (ID, A*B). Required: every response matches in order and none is missing or extra.
- `issue_en` gating: drive `issue_en` low for 3 cycles during contention. Required: `req_ready`=0 during those cycles, in-flight responses still arrive, and `ptr` resumes from its held value.
- Reset mid-flight: assert `rst_n` low 3 cycles after 3 grants. Required: `rsp_valid`=0 and `busy`=0 immediately. No stale responses after release, and the first new grant goes to requester 0.
